// File: rtl/fifo_rd_ctrl_block.sv
// fifo_rd_ctrl_block: read-side control for an asynchronous FIFO.
// It keeps the binary and Gray read pointers, the memory read address and
// registered empty / almost-empty / occupancy flags, plus a sticky underflow flag.
// The write-side Gray pointer is compared against the next read pointer.
// Optional feature macro: FIFO_RD_SYNC_EN. When it is defined, the incoming write
// Gray pointer passes through a 2-flop synchroniser on rd_clk. When it is not
// defined, the caller must supply a pointer that is already synchronised.
//
// Handshake: rd_read is a one-cycle pop request. It is honoured (rd_pop) only
// when rd_fifo_empty is low. A request made while the FIFO is empty is dropped,
// and it sets rd_underflow on the following edge. There is no ready/stall path.
module fifo_rd_ctrl_block #(
    parameter int AW       = 2,
    parameter int AE_LEVEL = 1
) (
    input  logic          rd_clk,
    input  logic          reset,
    input  logic [AW:0]   rd_wr_gray_pointer,
    input  logic          rd_read,
    input  logic          rd_underflow_clr,
    output logic          rd_fifo_empty,
    output logic          rd_almost_empty,
    output logic [AW:0]   rd_count,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   rd_gray_pointer,
    output logic          rd_underflow
);

    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] rd_bin_q, rd_bin_d;
    logic [AW:0] rd_gray_q, rd_gray_d;
    logic        empty_q, empty_d;
    logic        ae_q, ae_d;
    logic [AW:0] count_q, count_d;
    logic        underflow_q, underflow_d;

    logic [AW:0] wr_gray_s;
    logic [AW:0] wr_bin_s;
    logic        rd_pop;

`ifdef FIFO_RD_SYNC_EN
    logic [AW:0] sync1_q, sync1_d;
    logic [AW:0] sync2_q, sync2_d;

    // Two-stage synchroniser next values for the write pointer.
    always_comb begin
        sync1_d = rd_wr_gray_pointer;
        sync2_d = sync1_q;
    end

    // Synchroniser flops; reset clears both stages.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign wr_gray_s = sync2_q;
`else
    assign wr_gray_s = rd_wr_gray_pointer;
`endif

    // Pop qualification, pointer advance and next-flag computation.
    always_comb begin
        wr_bin_s    = gray2bin(wr_gray_s);
        rd_pop      = rd_read & ~empty_q;
        rd_bin_d    = rd_bin_q + {{AW{1'b0}}, rd_pop};
        rd_gray_d   = bin2gray(rd_bin_d);
        empty_d     = (rd_gray_d == wr_gray_s);
        count_d     = wr_bin_s - rd_bin_d;
        ae_d        = (count_d <= AE_LVL);
        // Clear first so that a set in the same cycle wins.
        underflow_d = underflow_q;
        if (rd_underflow_clr) underflow_d = 1'b0;
        if (rd_read && empty_q) underflow_d = 1'b1;
    end

    // Read-side state register; reset overrides any read or clear.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_fifo_empty   = empty_q;
    assign rd_almost_empty = ae_q;
    assign rd_count        = count_q;
    assign rd_addr         = rd_bin_q[AW-1:0];
    assign rd_gray_pointer = rd_gray_q;
    assign rd_underflow    = underflow_q;

endmodule

// File: doc/fifo_rd_ctrl_block.md
FIFO_RD_CTRL_BLOCK -- requirements
Module: fifo_rd_ctrl_block

Interface
REQ-001 Parameter AW, default 2, SHALL set address bits; DEPTH = 2^AW entries.
REQ-002 Parameter AE_LEVEL, default 1, SHALL set almost-empty threshold in entries; legal range 0..DEPTH.
REQ-003 rd_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 rd_wr_gray_pointer  input  AW+1  SHALL carry the write-side Gray pointer from the other clock domain.
REQ-006 rd_read  input  1  SHALL request a pop of one entry this cycle.
REQ-007 rd_underflow_clr  input  1  SHALL clear the sticky underflow flag.
REQ-008 rd_fifo_empty  output  1  SHALL indicate no readable entry (registered).
REQ-009 rd_almost_empty  output  1  SHALL indicate occupancy <= AE_LEVEL (registered).
REQ-010 rd_count  output  AW+1  SHALL give registered occupancy, 0..DEPTH.
REQ-011 rd_addr  output  AW  SHALL give the memory read address.
REQ-012 rd_gray_pointer  output  AW+1  SHALL give the read Gray pointer for the write domain.
REQ-013 rd_underflow  output  1  SHALL be a sticky read-while-empty error flag.

Function
REQ-014 Effective read rd_pop = rd_read AND NOT rd_fifo_empty; pointers SHALL advance only on rd_pop.
REQ-015 Binary read pointer (AW+1 bits) SHALL increment by 1 per rd_pop, wrapping modulo 2^(AW+1).
REQ-016 rd_addr SHALL equal binary pointer [AW-1:0]; rd_gray_pointer SHALL equal registered Gray(binary pointer) = (b>>1)^b.
REQ-017 Write pointer used internally (wr_gray_s) SHALL be converted Gray-to-binary (wr_bin_s) each cycle.
REQ-018 Next values SHALL be computed from next read pointer rd_bin_next: empty_next = (Gray(rd_bin_next) == wr_gray_s); count_next = (wr_bin_s - rd_bin_next) mod 2^(AW+1); ae_next = (count_next <= AE_LEVEL).
REQ-019 rd_fifo_empty, rd_count, rd_almost_empty SHALL register empty_next, count_next, ae_next every cycle (one-cycle latency from pop or wr_gray_s change).
REQ-020 Read on empty (rd_read=1, rd_fifo_empty=1) SHALL set rd_underflow next cycle and SHALL NOT move any pointer.
REQ-021 rd_underflow_clr SHALL clear rd_underflow next cycle; simultaneous set and clear SHALL leave rd_underflow=1.
REQ-022 Full FIFO (count=DEPTH) SHALL be reported as rd_count=DEPTH, rd_fifo_empty=0; no full flag from this block.
REQ-023 Pointer wrap (binary 2^(AW+1)-1 to 0) SHALL produce correct empty/count with no glitch cycle.

Reset
REQ-024 Reset SHALL force: binary and Gray pointers 0, rd_addr=0, rd_gray_pointer=0, rd_fifo_empty=1, rd_almost_empty=1, rd_count=0, rd_underflow=0, synchroniser stages 0.
REQ-025 Reset SHALL take priority over rd_read and rd_underflow_clr, including mid-operation; outputs SHALL show reset values the cycle after reset is sampled.

Configuration
REQ-026 Macro FIFO_RD_SYNC_EN defined: rd_wr_gray_pointer SHALL pass through a 2-flop synchroniser on rd_clk to form wr_gray_s (2 extra cycles latency).
REQ-027 FIFO_RD_SYNC_EN undefined: wr_gray_s SHALL equal rd_wr_gray_pointer directly (caller supplies a synchronised pointer); all other behaviour identical.

Verification (AW=2, AE_LEVEL=1, FIFO_RD_SYNC_EN defined)
REQ-028 Reset asserted 1 cycle -> rd_fifo_empty=1, rd_almost_empty=1, rd_count=0, rd_addr=0, rd_gray_pointer=000, rd_underflow=0.
REQ-029 rd_wr_gray_pointer 000->001 held -> rd_fifo_empty falls and rd_count=1 on 3rd rd_clk edge; rd_almost_empty stays 1.
REQ-030 rd_wr_gray_pointer=110 (4 entries), rd_read held 4 cycles -> rd_count 4,3,2,1,0; rd_addr 0,1,2,3; rd_gray_pointer 001,011,010,110; rd_almost_empty 0 until count<=1; rd_fifo_empty=1 after 4th pop.
REQ-031 rd_read=1 while empty -> rd_underflow=1, rd_addr unchanged; rd_underflow_clr pulse -> 0 next cycle; set and clear same cycle -> stays 1.
REQ-032 8 writes/8 reads interleaved through wrap -> rd_gray_pointer returns 100->000, rd_count never exceeds 4, empty correct each cycle.
REQ-033 reset pulsed with rd_count=3 and rd_read=1 -> next cycle all outputs at REQ-024 values; undefined-macro build repeats REQ-029 with empty falling on 1st edge.
